// File: rtl/mem_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_ctrl_pkg: shared encodings for the byte-serialising memory sequencer
// Rev 1.0
// ============================================================================
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Address bits [17:16] equal to this value select memory-mapped IO.
  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_bytes = 3'd1;
      SIZE_HALF: size_to_bytes = 3'd2;
      default:   size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_ctrl: arbitrates fetch and load/store onto the 8-bit RAM/IO bus
// Rev 1.0
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       asm_data;
  logic [31:0]       next_asm;
  logic [2:0]        n;
  logic [2:0]        i;
  logic [2:0]        c;
  logic              is_fetch;
  logic              last_ls;
  logic              dv;
  logic              stalled;

  logic [2:0] eff_i;
  logic       issuing;
  logic       ls_go;
  logic       if_go;
  logic       grant_if;
  logic       grant_ls;

  // After a pause the in-flight read is lost, so issue restarts at the capture point.
  assign eff_i   = stalled ? c : i;
  assign issuing = (state == ST_READ) && (eff_i < n);

  assign ls_go    = ls_req && !ls_done;
  assign if_go    = if_req && !if_done && !if_cancel;
  assign grant_if = if_go && (!ls_go || last_ls);
  assign grant_ls = ls_go && !grant_if;

  always_comb begin
    next_asm = asm_data;
    next_asm[{c[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    if (issuing) begin
      mem_a = addr + ADDR_W'(eff_i);
    end else if (state == ST_WRITE) begin
      mem_a    = addr + ADDR_W'(i);
      mem_wr   = 1'b1;
      mem_dout = wdata[{i[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      wdata    <= '0;
      asm_data <= '0;
      n        <= '0;
      i        <= '0;
      c        <= '0;
      is_fetch <= 1'b0;
      last_ls  <= 1'b0;
      dv       <= 1'b0;
      stalled  <= 1'b0;
      if_done  <= 1'b0;
      if_data  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (rdy) begin
        stalled <= 1'b0;
        case (state)
          ST_IDLE: begin
            dv <= 1'b0;
            i  <= '0;
            c  <= '0;
            if (grant_if || grant_ls) begin
              is_fetch <= grant_if;
              last_ls  <= grant_ls;
              addr     <= grant_if ? if_addr : ls_addr;
              n        <= grant_if ? 3'd4 : size_to_bytes(ls_size);
              wdata    <= ls_wdata;
              asm_data <= '0;
              state    <= (grant_ls && ls_wr) ? ST_WRITE : ST_READ;
            end
          end
          ST_READ: begin
            if (is_fetch && if_cancel) begin
              state <= ST_IDLE;
              dv    <= 1'b0;
            end else begin
              dv <= issuing;
              i  <= issuing ? eff_i + 3'd1 : eff_i;
              // mem_din seen on the resume edge belongs to the host, not to us.
              if (dv && !stalled) begin
                asm_data <= next_asm;
                c        <= c + 3'd1;
                if (c == n - 3'd1) begin
                  state <= ST_IDLE;
                  dv    <= 1'b0;
                  if (is_fetch) begin
                    if_done <= 1'b1;
                    if_data <= next_asm;
                  end else begin
                    ls_done  <= 1'b1;
                    ls_rdata <= next_asm;
                  end
                end
              end
            end
          end
          ST_WRITE: begin
            if (i == n - 3'd1) begin
              state   <= ST_IDLE;
              ls_done <= 1'b1;
            end else begin
              i <= i + 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a registered byte RAM model
// Rev 1.0
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [32:0] exp_ls[$];   // bit 32 set: compare ls_rdata
  logic [31:0] exp_if[$];
  logic [40:0] bus_log[$];  // {mem_wr, mem_a, mem_dout} per rdy-high bus cycle

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registered read; the host owns the bus while rdy is low.
  always @(posedge clk) begin
    mem_din <= rdy ? rd(mem_a) : 8'hEE;
    if (rdy && mem_wr) ram[mem_a] = mem_dout;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (if_done) begin
        if (exp_if.size() == 0) check("if_done_unexpected", 64'(if_done), 64'd0);
        else check("if_data", 64'(if_data), 64'(exp_if.pop_front()));
      end
      if (ls_done) begin
        if (exp_ls.size() == 0) check("ls_done_unexpected", 64'(ls_done), 64'd0);
        else begin
          logic [32:0] e;
          e = exp_ls.pop_front();
          if (e[32]) check("ls_rdata", 64'(ls_rdata), 64'(e[31:0]));
        end
      end
      if (rdy && (mem_a != 32'd0 || mem_wr)) bus_log.push_back({mem_wr, mem_a, mem_dout});
    end
  end

  task automatic wait_done(input bit want_if, input int base, output int rel);
    bit seen;
    seen = 1'b0;
    rel  = -1;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (want_if ? if_done : ls_done) begin
        seen = 1'b1;
        rel  = cyc - base;
      end
    end
    if (!seen) check(want_if ? "if_done_timeout" : "ls_done_timeout", 64'(seen), 64'd1);
  endtask

  // Runs a fetch and a load (held for a second load when hold_ls) to completion.
  task automatic run_pair(input bit hold_ls, input int base,
                          output int t_ls1, output int t_ls2, output int t_if);
    int n_ls;
    int want;
    n_ls  = 0;
    want  = hold_ls ? 2 : 1;
    t_ls1 = -1;
    t_ls2 = -1;
    t_if  = -1;
    for (int t = 0; t < 80 && !(n_ls == want && t_if >= 0); t++) begin
      @(negedge clk);
      if (if_done) begin
        t_if   = cyc - base;
        if_req = 1'b0;
      end
      if (ls_done) begin
        n_ls++;
        if (n_ls == 1) t_ls1 = cyc - base;
        else t_ls2 = cyc - base;
        if (n_ls == want) ls_req = 1'b0;
      end
    end
  endtask

  task automatic check_bus(input string tag, input logic [40:0] exp_seq[$]);
    check({tag, "_count"}, 64'(bus_log.size()), 64'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size() && k < bus_log.size(); k++)
      check(tag, 64'(bus_log[k]), 64'(exp_seq[k]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, rel, t1, t2, ti, seen;
    logic [40:0] exp_seq[$];

    rst = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h44; ram[32'h201] = 8'h33; ram[32'h202] = 8'h22; ram[32'h203] = 8'h11;
    ram[32'h300] = 8'hAA; ram[32'h301] = 8'hBB; ram[32'h302] = 8'hCC; ram[32'h303] = 8'hDD;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", 64'(mem_a), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_dout", 64'(mem_dout), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_if_data", 64'(if_data), 64'd0);
    check("rst_ls_done", 64'(ls_done), 64'd0);
    check("rst_ls_rdata", 64'(ls_rdata), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Word fetch from 0x100.
    bus_log.delete();
    base = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    exp_if.push_back(32'h0000_0013);
    wait_done(1'b1, base, rel);
    if_req = 1'b0;
    check("fetch_done_cycle", 64'(rel), 64'd6);
    exp_seq.delete();
    for (int k = 0; k < 4; k++) exp_seq.push_back({1'b0, 32'(32'h100 + k), 8'h00});
    check_bus("fetch_bus", exp_seq);
    @(posedge clk); #1;

    // Simultaneous load and fetch after a fetch grant: load first, fetch next, held load last.
    base = cyc;
    ls_addr = 32'h200; ls_size = 2'd2; ls_wr = 1'b0; ls_req = 1'b1;
    if_addr = 32'h300; if_req = 1'b1;
    exp_ls.push_back({1'b1, 32'h1122_3344});
    exp_if.push_back(32'hDDCC_BBAA);
    exp_ls.push_back({1'b1, 32'h1122_3344});
    run_pair(1'b1, base, t1, t2, ti);
    check("cont_ls1_cycle", 64'(t1), 64'd6);
    check("cont_if_cycle", 64'(ti), 64'd12);
    check("cont_ls2_cycle", 64'(t2), 64'd18);
    @(posedge clk); #1;

    // After a load/store grant, a simultaneous fetch wins.
    base = cyc;
    ls_req = 1'b1; if_req = 1'b1;
    exp_if.push_back(32'hDDCC_BBAA);
    exp_ls.push_back({1'b1, 32'h1122_3344});
    run_pair(1'b0, base, t1, t2, ti);
    check("fair_if_cycle", 64'(ti), 64'd6);
    check("fair_ls_cycle", 64'(t1), 64'd12);
    @(posedge clk); #1;

    // Half store across the 0x1FFFF/0x20000 boundary.
    bus_log.delete();
    base = cyc;
    ls_addr = 32'h0001_FFFF; ls_size = 2'd1; ls_wr = 1'b1; ls_wdata = 32'hAABB_CCDD; ls_req = 1'b1;
    exp_ls.push_back({1'b0, 32'h0});
    wait_done(1'b0, base, rel);
    ls_req = 1'b0;
    check("st_half_done_cycle", 64'(rel), 64'd3);
    exp_seq.delete();
    exp_seq.push_back({1'b1, 32'h0001_FFFF, 8'hDD});
    exp_seq.push_back({1'b1, 32'h0002_0000, 8'hCC});
    check_bus("st_half_bus", exp_seq);
    check("st_half_mem0", 64'(rd(32'h0001_FFFF)), 64'hDD);
    check("st_half_mem1", 64'(rd(32'h0002_0000)), 64'hCC);
    check("st_half_mem2", 64'(rd(32'h0002_0001)), 64'h00);
    @(posedge clk); #1;

    // Byte load: zero-extended, done on the 2nd cycle after grant.
    base = cyc;
    ls_addr = 32'h0001_FFFF; ls_size = 2'd0; ls_wr = 1'b0; ls_req = 1'b1;
    exp_ls.push_back({1'b1, 32'h0000_00DD});
    wait_done(1'b0, base, rel);
    ls_req = 1'b0;
    check("ld_byte_done_cycle", 64'(rel), 64'd3);
    @(posedge clk); #1;

    // Fetch with rdy low for three edges after byte 1 is on the bus.
    bus_log.delete();
    base = cyc;
    if_addr = 32'h300; if_req = 1'b1;
    exp_if.push_back(32'hDDCC_BBAA);
    repeat (3) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    wait_done(1'b1, base, rel);
    if_req = 1'b0;
    check("pause_done_cycle", 64'(rel), 64'd10);
    exp_seq.delete();
    exp_seq.push_back({1'b0, 32'h300, 8'h00});
    exp_seq.push_back({1'b0, 32'h301, 8'h00});
    exp_seq.push_back({1'b0, 32'h301, 8'h00});
    exp_seq.push_back({1'b0, 32'h302, 8'h00});
    exp_seq.push_back({1'b0, 32'h303, 8'h00});
    check_bus("pause_bus", exp_seq);
    @(posedge clk); #1;

    // Cancel in the second cycle of a fetch, then a load.
    if_addr = 32'h100; if_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 if_cancel = 1'b1; if_req = 1'b0;
    @(posedge clk);
    #1 if_cancel = 1'b0;
    @(negedge clk);
    check("flush_idle_mem_a", 64'(mem_a), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(if_done);
    end
    check("flush_no_if_done", 64'(seen), 64'd0);
    @(posedge clk); #1;
    base = cyc;
    ls_addr = 32'h200; ls_size = 2'd2; ls_wr = 1'b0; ls_req = 1'b1;
    exp_ls.push_back({1'b1, 32'h1122_3344});
    wait_done(1'b0, base, rel);
    ls_req = 1'b0;
    check("flush_ld_done_cycle", 64'(rel), 64'd6);
    @(posedge clk); #1;

    // Reset in the middle of a word store.
    ls_addr = 32'h500; ls_size = 2'd2; ls_wr = 1'b1; ls_wdata = 32'h5566_7788; ls_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ls_req = 1'b0;
    #1;
    check("mrst_mem_a", 64'(mem_a), 64'd0);
    check("mrst_mem_wr", 64'(mem_wr), 64'd0);
    check("mrst_mem_dout", 64'(mem_dout), 64'd0);
    check("mrst_if_data", 64'(if_data), 64'd0);
    check("mrst_ls_done", 64'(ls_done), 64'd0);
    check("mrst_ls_rdata", 64'(ls_rdata), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mrst_mem_500", 64'(rd(32'h500)), 64'h88);
    check("mrst_mem_501", 64'(rd(32'h501)), 64'h00);
    check("mrst_mem_502", 64'(rd(32'h502)), 64'h00);
    check("mrst_mem_503", 64'(rd(32'h503)), 64'h00);

    check("sb_if_drained", 64'(exp_if.size()), 64'd0);
    check("sb_ls_drained", 64'(exp_ls.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
